// File: rtl/galois_mul_pipe.sv
// galois_mul_pipe: pipelined GF(2^WIDTH) multiplier with valid/ready handshakes,
// a per-operation reduction polynomial and a pass-through tag.
// The shift-and-add is spread over STAGES register stages. Each stage handles
// WIDTH/STAGES multiplier bits. The last stage register drives the outputs.
// A single global stall holds every stage while the output is blocked.
// Optional feature: define GALOIS_MUL_ACC_EN to add a GF multiply-accumulate
// register that is selected per operation with acc_i and cleared with acc_clr_i.
module galois_mul_pipe #(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     first_op_i,
    input  logic [WIDTH-1:0]     second_op_i,
    input  logic [WIDTH-1:0]     poly_op_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 acc_i,
    input  logic                 acc_clr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     result_o,
    output logic [TAG_WIDTH-1:0] tag_o
);

    // Reject configurations where the multiplier bits cannot be split evenly.
    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_error
        $error("galois_mul_pipe: STAGES must lie in 1..WIDTH and divide WIDTH");
    end

    localparam int BPS = WIDTH / STAGES;

    typedef struct packed {
        logic [WIDTH-1:0] a_shift;
        logic [WIDTH-1:0] partial;
    } step_t;

    // One stage's slice of the shift-and-add, starting at multiplier bit 'base'.
    // For each bit the partial product is accumulated first. Then a is doubled
    // modulo the polynomial, which drops the implicit x^WIDTH term.
    function automatic step_t gf_step(
        input logic [WIDTH-1:0] a_in,
        input logic [WIDTH-1:0] b_in,
        input logic [WIDTH-1:0] poly_in,
        input logic [WIDTH-1:0] part_in,
        input int               base
    );
        step_t            res;
        logic [WIDTH-1:0] b_bits;
        res.a_shift = a_in;
        res.partial = part_in;
        b_bits      = b_in >> base;
        for (int j = 0; j < BPS; j++) begin
            res.partial = res.partial ^ (b_bits[0] ? res.a_shift : {WIDTH{1'b0}});
            res.a_shift = (res.a_shift << 1'b1) ^
                          (res.a_shift[WIDTH-1] ? poly_in : {WIDTH{1'b0}});
            b_bits      = b_bits >> 1'b1;
        end
        return res;
    endfunction

    logic [STAGES-1:0]                valid_r;
    logic [STAGES-1:0][WIDTH-1:0]     a_r;
    logic [STAGES-1:0][WIDTH-1:0]     b_r;
    logic [STAGES-1:0][WIDTH-1:0]     poly_r;
    logic [STAGES-1:0][WIDTH-1:0]     part_r;
    logic [STAGES-1:0][TAG_WIDTH-1:0] tag_r;
    step_t [STAGES-1:0]               step_s;
    logic                             advance_s;
`ifdef GALOIS_MUL_ACC_EN
    logic [STAGES-1:0]                accf_r;
    logic [WIDTH-1:0]                 acc_r;
    logic                             out_fire_s;
`endif

    // The pipeline moves only when the output register is empty or is being drained.
    assign advance_s   = ~valid_r[STAGES-1] | out_ready_i;
    assign in_ready_o  = advance_s;
    assign out_valid_o = valid_r[STAGES-1];
    assign tag_o       = tag_r[STAGES-1];

    // Combinational step of every stage: stage 0 is fed by the ports, later stages by the previous register.
    always_comb begin
        step_s[0] = gf_step(first_op_i, second_op_i, poly_op_i, {WIDTH{1'b0}}, 0);
        for (int k = 1; k < STAGES; k++) begin
            step_s[k] = gf_step(a_r[k-1], b_r[k-1], poly_r[k-1], part_r[k-1], k * BPS);
        end
    end

    // Stage registers: the valid bits always shift on advance, and a stage's data loads only with a valid op.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_r <= {STAGES{1'b0}};
            a_r     <= {(STAGES*WIDTH){1'b0}};
            b_r     <= {(STAGES*WIDTH){1'b0}};
            poly_r  <= {(STAGES*WIDTH){1'b0}};
            part_r  <= {(STAGES*WIDTH){1'b0}};
            tag_r   <= {(STAGES*TAG_WIDTH){1'b0}};
`ifdef GALOIS_MUL_ACC_EN
            accf_r  <= {STAGES{1'b0}};
`endif
        end else if (advance_s) begin
            valid_r[0] <= in_valid_i;
            if (in_valid_i) begin
                a_r[0]    <= step_s[0].a_shift;
                b_r[0]    <= second_op_i;
                poly_r[0] <= poly_op_i;
                part_r[0] <= step_s[0].partial;
                tag_r[0]  <= tag_i;
`ifdef GALOIS_MUL_ACC_EN
                accf_r[0] <= acc_i;
`endif
            end
            for (int k = 1; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
                if (valid_r[k-1]) begin
                    a_r[k]    <= step_s[k].a_shift;
                    b_r[k]    <= b_r[k-1];
                    poly_r[k] <= poly_r[k-1];
                    part_r[k] <= step_s[k].partial;
                    tag_r[k]  <= tag_r[k-1];
`ifdef GALOIS_MUL_ACC_EN
                    accf_r[k] <= accf_r[k-1];
`endif
                end
            end
        end
    end

`ifdef GALOIS_MUL_ACC_EN
    assign out_fire_s = out_valid_o & out_ready_i;
    assign result_o   = part_r[STAGES-1] ^ (accf_r[STAGES-1] ? acc_r : {WIDTH{1'b0}});

    // Accumulator: a clear wins over an accumulate on the same edge. The fired result still sees the old value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (acc_clr_i) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (out_fire_s && accf_r[STAGES-1]) begin
            acc_r <= result_o;
        end
    end

    // The last stage's operand copies and its shifted multiplicand are never consumed.
    logic unused_s;
    assign unused_s = ^{a_r[STAGES-1], b_r[STAGES-1], poly_r[STAGES-1], step_s[STAGES-1].a_shift};
`else
    assign result_o = part_r[STAGES-1];

    // Without the accumulator, the acc controls and the last stage's operand copies have no consumer.
    logic unused_s;
    assign unused_s = ^{a_r[STAGES-1], b_r[STAGES-1], poly_r[STAGES-1],
                        step_s[STAGES-1].a_shift, acc_i, acc_clr_i};
`endif

endmodule

// File: tb/tb_galois_mul_pipe.sv
// tb_galois_mul_pipe: directed and randomized checks of galois_mul_pipe against
// a carry-less-multiply-then-reduce reference model and an in-order scoreboard.
module tb_galois_mul_pipe;

    localparam int WIDTH     = 8;
    localparam int STAGES    = 4;
    localparam int TAG_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_op = '0;
    logic [WIDTH-1:0]     b_op = '0;
    logic [WIDTH-1:0]     poly = '0;
    logic [TAG_WIDTH-1:0] tag_in = '0;
    logic                 acc = 1'b0;
    logic                 acc_clr = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [WIDTH-1:0]     result;
    logic [TAG_WIDTH-1:0] tag_out;

    galois_mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_WIDTH(TAG_WIDTH)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .first_op_i  (a_op),
        .second_op_i (b_op),
        .poly_op_i   (poly),
        .tag_i       (tag_in),
        .acc_i       (acc),
        .acc_clr_i   (acc_clr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .tag_o       (tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]     prod;
        logic [TAG_WIDTH-1:0] tag;
        logic                 flag;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] log_res[$];
    int               log_cyc[$];
    logic [WIDTH-1:0] acc_m = '0;
    int               checks_cnt = 0;
    int               errors_cnt = 0;
    int               cyc = 0;
    logic             last_in_fire = 1'b0;
    logic             last_out_fire = 1'b0;

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] req);
        checks_cnt++;
        if (obs !== req) begin
            errors_cnt++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", name, obs, req);
        end
    endtask

    // Reference: full carry-less product, then long division by x^WIDTH + poly.
    function automatic logic [WIDTH-1:0] gf_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] p);
        logic [2*WIDTH-1:0] prod;
        logic [2*WIDTH-1:0] modulus;
        prod    = '0;
        modulus = {{(WIDTH-1){1'b0}}, 1'b1, p};
        for (int i = 0; i < WIDTH; i++)
            if (b[i]) prod = prod ^ ({{WIDTH{1'b0}}, a} << i);
        for (int i = 2*WIDTH-1; i >= WIDTH; i--)
            if (prod[i]) prod = prod ^ (modulus << (i - WIDTH));
        return prod[WIDTH-1:0];
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < log_res.size()) return 32'(log_res[i]);
        return 32'hDEAD_BEEF;
    endfunction

    // Inputs are already driven. Settle, score the handshakes of the coming edge, then move to the next negedge.
    task automatic cycle();
        exp_t             e;
        logic [WIDTH-1:0] exp_r;
        #1;
        last_in_fire  = in_valid && in_ready;
        last_out_fire = out_valid && out_ready;
        if (last_out_fire) begin
            check_eq("sb_underflow", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                exp_r = e.prod ^ (e.flag ? acc_m : '0);
                check_eq("sb_result", 32'(result), 32'(exp_r));
                check_eq("sb_tag", 32'(tag_out), 32'(e.tag));
                log_res.push_back(result);
                log_cyc.push_back(cyc);
`ifdef GALOIS_MUL_ACC_EN
                if (!acc_clr && e.flag) acc_m = exp_r;
`endif
            end
        end
`ifdef GALOIS_MUL_ACC_EN
        if (acc_clr) acc_m = '0;
`endif
        if (last_in_fire) begin
            e.prod = gf_ref(a_op, b_op, poly);
            e.tag  = tag_in;
`ifdef GALOIS_MUL_ACC_EN
            e.flag = acc;
`else
            e.flag = 1'b0;
`endif
            exp_q.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply(input logic v, input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                         input logic [WIDTH-1:0] p_v, input logic [TAG_WIDTH-1:0] t_v, input logic ac);
        in_valid = v; a_op = a_v; b_op = b_v; poly = p_v; tag_in = t_v; acc = ac;
    endtask

    task automatic clear_log();
        log_res.delete();
        log_cyc.delete();
    endtask

    task automatic wait_log(input int n, input string name);
        int k = 0;
        while (log_res.size() < n && k < 50) begin cycle(); k++; end
        check_eq(name, 32'(log_res.size()), 32'(n));
    endtask

    task automatic drain();
        int k = 0;
        in_valid = 1'b0; acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && k < 50) begin cycle(); k++; end
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_one(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                           input logic [WIDTH-1:0] p_v, input logic [TAG_WIDTH-1:0] t_v, input logic ac);
        int n0 = log_res.size();
        int k = 0;
        out_ready = 1'b1;
        apply(1'b1, a_v, b_v, p_v, t_v, ac);
        cycle();
        while (!last_in_fire && k < 20) begin cycle(); k++; end
        in_valid = 1'b0; acc = 1'b0;
        wait_log(n0 + 1, "one_done");
    endtask

    logic [WIDTH-1:0] b2b_a [3] = '{8'h57, 8'h02, 8'h00};
    logic [WIDTH-1:0] b2b_b [3] = '{8'h13, 8'h80, 8'hFF};
    logic [WIDTH-1:0] st_a  [4] = '{8'h57, 8'h02, 8'h00, 8'h57};
    logic [WIDTH-1:0] st_b  [4] = '{8'h13, 8'h80, 8'hFF, 8'h83};

    initial begin
        int lat;
        int idx;
        int stalls;
        int stale;
        int k;
        logic started;

        // Reset state.
        @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_tag", 32'(tag_out), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: out_valid rises STAGES-1 edges after the accept edge, so the
        // accept edge plus three more makes four edges in all.
        clear_log();
        apply(1'b1, 8'h57, 8'h83, 8'h1B, 4'h5, 1'b0);
        cycle();
        check_eq("lat_accept", 32'(last_in_fire), 32'd1);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin cycle(); lat++; end
        check_eq("latency", 32'(lat), 32'(STAGES - 1));
        check_eq("lat_result", 32'(result), 32'hC1);
        check_eq("lat_tag", 32'(tag_out), 32'h5);
        drain();

        // Back-to-back stream: one op per cycle, results on consecutive cycles.
        clear_log();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, b2b_a[i], b2b_b[i], 8'h1B, 4'(i), 1'b0);
            #1 check_eq("b2b_in_ready", 32'(in_ready), 32'd1);
            cycle();
        end
        in_valid = 1'b0;
        wait_log(3, "b2b_count");
        check_eq("b2b_r0", log_at(0), 32'hFE);
        check_eq("b2b_r1", log_at(1), 32'h1B);
        check_eq("b2b_r2", log_at(2), 32'h00);
        check_eq("b2b_gap01", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
        check_eq("b2b_gap12", 32'(log_cyc[2] - log_cyc[1]), 32'd1);
        drain();

        // Backpressure: three stalled cycles once the first result shows; a fourth op waits at the input.
        clear_log();
        idx = 0; stalls = 0; started = 1'b0;
        for (int c = 0; c < 60 && log_res.size() < 4; c++) begin
            if (idx < 4) apply(1'b1, st_a[idx], st_b[idx], 8'h1B, 4'(idx + 8), 1'b0);
            else in_valid = 1'b0;
            if (out_valid) started = 1'b1;
            if (started && stalls < 3) begin
                out_ready = 1'b0;
                #1;
                check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                check_eq("stall_hold", 32'(result), 32'hFE);
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            cycle();
            if (last_in_fire) idx++;
        end
        in_valid = 1'b0;
        check_eq("stall_count", 32'(log_res.size()), 32'd4);
        check_eq("stall_r0", log_at(0), 32'hFE);
        check_eq("stall_r1", log_at(1), 32'h1B);
        check_eq("stall_r2", log_at(2), 32'h00);
        check_eq("stall_r3", log_at(3), 32'hC1);
        drain();

        // Per-operation polynomial.
        clear_log();
        apply(1'b1, 8'h80, 8'h02, 8'h1B, 4'h1, 1'b0);
        cycle();
        apply(1'b1, 8'h80, 8'h02, 8'h1D, 4'h2, 1'b0);
        cycle();
        in_valid = 1'b0;
        wait_log(2, "poly_count");
        check_eq("poly_1b", log_at(0), 32'h1B);
        check_eq("poly_1d", log_at(1), 32'h1D);
        drain();

        // Accumulate sequence (with the feature), or the acc controls have no effect (without it).
        clear_log();
        run_one(8'h57, 8'h83, 8'h1B, 4'h1, 1'b1);
        run_one(8'h57, 8'h13, 8'h1B, 4'h2, 1'b1);
        acc_clr = 1'b1;
        cycle();
        acc_clr = 1'b0;
        run_one(8'h57, 8'h13, 8'h1B, 4'h3, 1'b1);
        check_eq("acc_r0", log_at(0), 32'hC1);
`ifdef GALOIS_MUL_ACC_EN
        check_eq("acc_r1", log_at(1), 32'h3F);
`else
        check_eq("noacc_r1", log_at(1), 32'hFE);
`endif
        check_eq("acc_r2", log_at(2), 32'hFE);
        drain();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a_op      = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            b_op      = ($urandom_range(0, 7) == 0) ? {{(WIDTH-1){1'b0}}, 1'b1} : WIDTH'($urandom);
            poly      = WIDTH'($urandom);
            tag_in    = TAG_WIDTH'($urandom);
            acc       = ($urandom_range(0, 1) != 0);
            acc_clr   = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1 check_eq("ready_rule", 32'(in_ready), 32'((!out_valid) || out_ready));
            cycle();
        end
        drain();

        // Asynchronous reset with three ops in flight.
        clear_log();
        out_ready = 1'b0;
        apply(1'b1, 8'h57, 8'h83, 8'h1B, 4'h1, 1'b0);
        cycle();
        apply(1'b1, 8'h57, 8'h13, 8'h1B, 4'h2, 1'b0);
        cycle();
        apply(1'b1, 8'h02, 8'h80, 8'h1B, 4'h3, 1'b0);
        cycle();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin cycle(); k++; end
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        check_eq("pre_rst_result", 32'(result), 32'hC1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst_result", 32'(result), 32'd0);
        check_eq("async_rst_tag", 32'(tag_out), 32'd0);
        exp_q.delete();
        acc_m = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            #1 stale += int'(out_valid);
            cycle();
        end
        check_eq("stale_after_reset", 32'(stale), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
